exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception control unit, directly downstream of the main decoder.
- Consumes the decoder's NotAnInstr and ERet flags, plus an external interrupt request, and owns the exception state: ELR, ESR and a handler-mode flag.
- Drives the PC-redirect controls into fetch: vector jump on exception, ELR jump on ERET.
- Serves system-register reads for MRS.

Parameters:
- N, 64: datapath/PC width.
- EXC_VECTOR, 64'hD8: handler entry address driven on EVAddr.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; state clears on the rising clk edge where reset==0.
- valid  in  1  current instruction is valid; NotAnInstr/ERet are ignored when 0.
- NotAnInstr  in  1  decoder: undefined opcode.
- ERet  in  1  decoder: ERET instruction.
- pc  in  N  PC of the instruction carrying NotAnInstr/ERet.
- instr  in  32  that instruction's encoding.
- ExtIRQ  in  1  external interrupt request; level, held until ExtIAck.
- ExtIAck  out  1  one-cycle pulse when the interrupt is taken.
- Exc  out  1  one-cycle pulse: fetch must load EVAddr.
- EVAddr  out  N  constant EXC_VECTOR.
- ERetTaken  out  1  one-cycle pulse: fetch must load ELR_o.
- ELR_o  out  N  current ELR.
- InHandler  out  1  1 while in state HANDLER.
- sysreg_sel  in  2  MRS select: 00 ELR, 01 ESR, 10 status, 11 cycle count.
- sysreg_rdata  out  N  combinational read data.

Behaviour:
- Reset (reset==0 at the edge):
  - State NORMAL; ELR=0, ESR=0.
  - Exc, ERetTaken, ExtIAck = 0; InHandler = 0.
  - Reset wins over every other event in that cycle, including mid-handler.
- Two states, NORMAL and HANDLER. All outputs are registered except EVAddr, ELR_o and sysreg_rdata. Event-to-pulse latency is 1 cycle: the event is sampled at edge k and the pulse is high during cycle k+1.
- NORMAL, event priority is NotAnInstr > ERet > ExtIRQ (NotAnInstr/ERet count only with valid=1):
  - NotAnInstr: ELR<=pc; ESR<={instr,28'b0,4'h1}; Exc pulse; go HANDLER.
  - ERet (illegal outside the handler): ELR<=pc; ESR<={instr,28'b0,4'h3}; Exc pulse; go HANDLER.
  - ExtIRQ with no valid NotAnInstr/ERet: ELR<=pc; ESR<={32'b0,28'b0,4'h2}; Exc and ExtIAck pulse together; go HANDLER.
- HANDLER:
  - ExtIRQ is masked: no ExtIAck; the request stays pending while held.
  - valid ERet: ERetTaken pulse; go NORMAL; ELR/ESR unchanged.
  - valid NotAnInstr (double fault): ESR<={instr,28'b0,4'h4}; ELR unchanged; Exc pulse; stay HANDLER.
  - Simultaneous ERet and ExtIRQ: ERet taken. The IRQ is taken on the next cycle in NORMAL if still asserted, with ELR=pc of that cycle.
- No pulse lasts more than 1 cycle. Back-to-back events on consecutive cycles each produce their own pulse.
- sysreg_rdata is combinational:
  - 00 → ELR; 01 → ESR.
  - 10 → {62'b0, ExtIRQ, InHandler}.
  - 11 → see optional feature.

Optional Feature:
- Macro EXC_CYCLE_COUNT_EN.
- When defined:
  - A 32-bit counter increments each cycle in HANDLER and holds in NORMAL.
  - It clears on reset and on every NORMAL→HANDLER entry; it wraps from FFFF_FFFF to 0.
  - sysreg_sel 11 returns {32'b0, count}.
- When undefined: no counter is instantiated and sysreg_sel 11 returns 0.

Test Plan:
- Reset: hold reset=0 two cycles with ExtIRQ=1 and NotAnInstr=1 → all pulses 0, InHandler=0, ELR=ESR=0. After release, ExtIAck pulses exactly once.
- Undefined opcode: valid=1, NotAnInstr=1, pc=0x40, instr=0xFFFF_FFFF → next cycle Exc=1, EVAddr=0xD8. Then ELR=0x40, ESR=0xFFFF_FFFF_0000_0001, InHandler=1.
- Return: in HANDLER, valid ERet → ERetTaken=1 one cycle, ELR_o=0x40, InHandler=0 next cycle.
- Masked IRQ: ExtIRQ held high during HANDLER for 5 cycles → ExtIAck=0. Then ERet and ExtIRQ together → ERetTaken next cycle, then Exc+ExtIAck the cycle after, ESR code 2.
- Double fault: in HANDLER, NotAnInstr with pc=0xE0 → Exc pulse, ESR[3:0]=4, ELR still 0x40.
- With EXC_CYCLE_COUNT_EN: 10 cycles in HANDLER, sysreg_sel=11 → 10. After ERet, the count holds at its value. A new exception clears it to 0.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Decoder/fetch-side bundle for the exception control unit.
// The decoder/fetch side uses the master modport; exc_ctrl uses the slave modport.
interface exc_ctrl_if #(
    parameter int N = 64
);
    logic         valid;
    logic         NotAnInstr;
    logic         ERet;
    logic [N-1:0] pc;
    logic [31:0]  instr;
    logic         ExtIRQ;
    logic         ExtIAck;
    logic         Exc;
    logic [N-1:0] EVAddr;
    logic         ERetTaken;
    logic [N-1:0] ELR_o;
    logic         InHandler;
    logic [1:0]   sysreg_sel;
    logic [N-1:0] sysreg_rdata;

    modport master (
        output valid, NotAnInstr, ERet, pc, instr, ExtIRQ, sysreg_sel,
        input  ExtIAck, Exc, EVAddr, ERetTaken, ELR_o, InHandler, sysreg_rdata
    );

    modport slave (
        input  valid, NotAnInstr, ERet, pc, instr, ExtIRQ, sysreg_sel,
        output ExtIAck, Exc, EVAddr, ERetTaken, ELR_o, InHandler, sysreg_rdata
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception control unit: owns ELR/ESR/handler mode and drives fetch redirects.
// Optional handler cycle counter enabled by defining EXC_CYCLE_COUNT_EN.
module exc_ctrl #(
    parameter int          N          = 64,
    parameter logic [63:0] EXC_VECTOR = 64'hD8
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);
    typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

    localparam logic [3:0] CODE_UNDEF  = 4'h1;
    localparam logic [3:0] CODE_IRQ    = 4'h2;
    localparam logic [3:0] CODE_ERET   = 4'h3;
    localparam logic [3:0] CODE_DFAULT = 4'h4;

    state_t       state;
    logic [N-1:0] elr;
    logic [63:0]  esr;
    logic         exc;
    logic         eret_taken;
    logic         ext_iack;

    logic undef_ev;
    logic eret_ev;
    assign undef_ev = bus.valid & bus.NotAnInstr;
    assign eret_ev  = bus.valid & bus.ERet;

`ifdef EXC_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= NORMAL;
            elr        <= '0;
            esr        <= '0;
            exc        <= 1'b0;
            eret_taken <= 1'b0;
            ext_iack   <= 1'b0;
`ifdef EXC_CYCLE_COUNT_EN
            cycle_cnt  <= '0;
`endif
        end else begin
            // Pulses default low so none can outlive a single cycle.
            exc        <= 1'b0;
            eret_taken <= 1'b0;
            ext_iack   <= 1'b0;
            case (state)
                NORMAL: begin
                    if (undef_ev) begin
                        elr   <= bus.pc;
                        esr   <= {bus.instr, 28'b0, CODE_UNDEF};
                        exc   <= 1'b1;
                        state <= HANDLER;
                    end else if (eret_ev) begin
                        elr   <= bus.pc;
                        esr   <= {bus.instr, 28'b0, CODE_ERET};
                        exc   <= 1'b1;
                        state <= HANDLER;
                    end else if (bus.ExtIRQ) begin
                        elr      <= bus.pc;
                        esr      <= {32'b0, 28'b0, CODE_IRQ};
                        exc      <= 1'b1;
                        ext_iack <= 1'b1;
                        state    <= HANDLER;
                    end
`ifdef EXC_CYCLE_COUNT_EN
                    if (undef_ev || eret_ev || bus.ExtIRQ) cycle_cnt <= '0;
`endif
                end
                HANDLER: begin
                    // ExtIRQ is masked here; it stays pending until back in NORMAL.
                    if (undef_ev) begin
                        esr <= {bus.instr, 28'b0, CODE_DFAULT};
                        exc <= 1'b1;
                    end else if (eret_ev) begin
                        eret_taken <= 1'b1;
                        state      <= NORMAL;
                    end
`ifdef EXC_CYCLE_COUNT_EN
                    cycle_cnt <= cycle_cnt + 32'd1;
`endif
                end
                default: state <= NORMAL;
            endcase
        end
    end

    assign bus.Exc       = exc;
    assign bus.ERetTaken = eret_taken;
    assign bus.ExtIAck   = ext_iack;
    assign bus.InHandler = (state == HANDLER);
    assign bus.EVAddr    = EXC_VECTOR[N-1:0];
    assign bus.ELR_o     = elr;

    always_comb begin
        bus.sysreg_rdata = '0;
        case (bus.sysreg_sel)
            2'b00: bus.sysreg_rdata = elr;
            2'b01: bus.sysreg_rdata = N'(esr);
            2'b10: bus.sysreg_rdata = N'({bus.ExtIRQ, state == HANDLER});
`ifdef EXC_CYCLE_COUNT_EN
            2'b11: bus.sysreg_rdata = N'(cycle_cnt);
`else
            2'b11: bus.sysreg_rdata = '0;
`endif
            default: bus.sysreg_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_exc_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    exc_ctrl_if #(.N(64)) bus ();

    exc_ctrl #(.N(64), .EXC_VECTOR(64'hD8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_sr(input logic [1:0] sel, output logic [63:0] val);
        bus.sysreg_sel = sel;
        #1;
        val = bus.sysreg_rdata;
    endtask

    task automatic check_sr(input string tag, input logic [1:0] sel, input logic [63:0] exp);
        logic [63:0] v;
        read_sr(sel, v);
        check(tag, v, exp);
    endtask

    task automatic check_pulses(input string tag, input logic e, input logic r, input logic a);
        check({tag, "_exc"},   bus.Exc,       e);
        check({tag, "_eret"},  bus.ERetTaken, r);
        check({tag, "_iack"},  bus.ExtIAck,   a);
    endtask

    task automatic drive(input logic v, input logic ni, input logic er,
                         input logic [63:0] p, input logic [31:0] ins, input logic irq);
        bus.valid      = v;
        bus.NotAnInstr = ni;
        bus.ERet       = er;
        bus.pc         = p;
        bus.instr      = ins;
        bus.ExtIRQ     = irq;
    endtask

    logic [63:0] exp_cnt;

    initial begin
        bus.sysreg_sel = 2'b00;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h10, 32'h1234, 1'b1);

        // Reset held two cycles with pending events.
        for (int i = 0; i < 2; i++) begin
            step();
            check_pulses("rst", 1'b0, 1'b0, 1'b0);
            check("rst_inh", bus.InHandler, 1'b0);
            check_sr("rst_elr", 2'b00, 64'h0);
            check_sr("rst_esr", 2'b01, 64'h0);
        end

        // Release with IRQ still high: taken exactly once.
        drive(1'b0, 1'b0, 1'b0, 64'h10, 32'h0, 1'b1);
        reset = 1'b1;
        step();
        check_pulses("irq0", 1'b1, 1'b0, 1'b1);
        check("irq0_inh", bus.InHandler, 1'b1);
        check_sr("irq0_esr", 2'b01, 64'h2);
        check("irq0_elr", bus.ELR_o, 64'h10);
        bus.ExtIRQ = 1'b0;
        step();
        check_pulses("irq0b", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 64'h20, 32'h0, 1'b0);
        step();
        check_pulses("ret0", 1'b0, 1'b1, 1'b0);
        check("ret0_inh", bus.InHandler, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h24, 32'h0, 1'b0);
        step();
        check_pulses("ret0b", 1'b0, 1'b0, 1'b0);

        // NotAnInstr without valid is ignored.
        drive(1'b0, 1'b1, 1'b0, 64'h30, 32'hFFFF_FFFF, 1'b0);
        step();
        check_pulses("novalid", 1'b0, 1'b0, 1'b0);
        check("novalid_inh", bus.InHandler, 1'b0);

        // Undefined opcode.
        drive(1'b1, 1'b1, 1'b0, 64'h40, 32'hFFFF_FFFF, 1'b0);
        step();
        check_pulses("undef", 1'b1, 1'b0, 1'b0);
        check("undef_vec", bus.EVAddr, 64'hD8);
        check("undef_elr", bus.ELR_o, 64'h40);
        check_sr("undef_esr", 2'b01, 64'hFFFF_FFFF_0000_0001);
        check("undef_inh", bus.InHandler, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h44, 32'h0, 1'b1);
        step();
        check_pulses("undef_b", 1'b0, 1'b0, 1'b0);

        // IRQ masked in the handler.
        for (int i = 0; i < 5; i++) begin
            step();
            check_pulses("mask", 1'b0, 1'b0, 1'b0);
        end
        check_sr("mask_status", 2'b10, 64'h3);

        // Double fault keeps ELR.
        drive(1'b1, 1'b1, 1'b0, 64'hE0, 32'hDEAD_BEEF, 1'b1);
        step();
        check_pulses("dfault", 1'b1, 1'b0, 1'b0);
        check_sr("dfault_esr", 2'b01, 64'hDEAD_BEEF_0000_0004);
        check("dfault_elr", bus.ELR_o, 64'h40);
        check("dfault_inh", bus.InHandler, 1'b1);

        // ERet with IRQ pending: return first, IRQ on the following cycle.
        drive(1'b1, 1'b0, 1'b1, 64'h100, 32'h0, 1'b1);
        step();
        check_pulses("retirq", 1'b0, 1'b1, 1'b0);
        check("retirq_elr", bus.ELR_o, 64'h40);
        check("retirq_inh", bus.InHandler, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 64'h104, 32'h0, 1'b1);
        step();
        check_pulses("retirq2", 1'b1, 1'b0, 1'b1);
        check_sr("retirq2_esr", 2'b01, 64'h2);
        check("retirq2_elr", bus.ELR_o, 64'h104);
        bus.ExtIRQ = 1'b0;
        step();
        check_pulses("retirq3", 1'b0, 1'b0, 1'b0);

        // Return, then back-to-back faults (second one is a double fault).
        drive(1'b1, 1'b0, 1'b1, 64'h108, 32'h0, 1'b0);
        step();
        check_pulses("ret1", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 64'h200, 32'h11, 1'b1);
        step();
        check_pulses("prio", 1'b1, 1'b0, 1'b0);
        check_sr("prio_esr", 2'b01, 64'h0000_0011_0000_0001);
        drive(1'b1, 1'b1, 1'b0, 64'h204, 32'h22, 1'b0);
        step();
        check_pulses("b2b", 1'b1, 1'b0, 1'b0);
        check_sr("b2b_esr", 2'b01, 64'h0000_0022_0000_0004);
        check("b2b_elr", bus.ELR_o, 64'h200);

        // Return, then illegal ERet in NORMAL.
        drive(1'b1, 1'b0, 1'b1, 64'h208, 32'h0, 1'b0);
        step();
        check_pulses("ret2", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 64'h300, 32'hD69F_03E0, 1'b0);
        step();
        check_pulses("ileret", 1'b1, 1'b0, 1'b0);
        check_sr("ileret_esr", 2'b01, 64'hD69F_03E0_0000_0003);
        check("ileret_elr", bus.ELR_o, 64'h300);
        check("ileret_inh", bus.InHandler, 1'b1);

        // Handler cycle counter: cleared at entry, one count per handler edge.
        drive(1'b0, 1'b0, 1'b0, 64'h304, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step();
`ifdef EXC_CYCLE_COUNT_EN
        exp_cnt = 64'd10;
`else
        exp_cnt = 64'd0;
`endif
        check_sr("cnt10", 2'b11, exp_cnt);
        drive(1'b1, 1'b0, 1'b1, 64'h308, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h30C, 32'h0, 1'b0);
        step();
        step();
`ifdef EXC_CYCLE_COUNT_EN
        exp_cnt = 64'd11;
`endif
        check_sr("cnt_hold", 2'b11, exp_cnt);
        drive(1'b1, 1'b1, 1'b0, 64'h400, 32'h0, 1'b0);
        step();
        check_sr("cnt_clr", 2'b11, 64'd0);
        check_pulses("cnt_exc", 1'b1, 1'b0, 1'b0);

        // Reset mid-handler wins over a simultaneous event.
        drive(1'b1, 1'b1, 1'b0, 64'h500, 32'h55, 1'b1);
        reset = 1'b0;
        step();
        check_pulses("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_inh", bus.InHandler, 1'b0);
        check("midrst_elr", bus.ELR_o, 64'h0);
        check_sr("midrst_esr", 2'b01, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
